// File: rtl/pc_pkg.sv
// Shared types for the program-counter stage: controller states, next-PC
// source selector and the cycle-counter width.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_HOLD = 3'd0,
    SRC_INC  = 3'd1,
    SRC_BR   = 3'd2,
    SRC_ABS  = 3'd3,
    SRC_RET  = 3'd4
  } pc_src_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Reset and clr only rewind the pointer; entries are
// never cleared because nothing reads above the pointer.
module ret_stack #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] r_sp;
  logic [D-1:0]  r_mem [DEPTH];
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign full     = (r_sp == PW'(DEPTH));
  assign empty    = (r_sp == '0);
  assign w_wr_idx = AW'(r_sp);
  // Guard the read index so an empty stack never addresses past the array.
  assign w_rd_idx = empty ? '0 : AW'(r_sp - PW'(1));
  assign dout     = r_mem[w_rd_idx];

  always_ff @(posedge Clk) begin
    if (push && !full) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sp <= '0;
    end else if (clr) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_sp <= r_sp + PW'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - PW'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Instruction-fetch program counter with start/run/halt controller, five-way
// next-PC selection and a small return-address stack for call/return.
module prog_counter
  import pc_pkg::*;
#(
  parameter int             D           = 12,
  parameter int             STACK_DEPTH = 4,
  parameter logic [D-1:0]   RESET_PC    = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [D-1:0]     target,
  input  logic             abs_jump_en,
  input  logic [D-1:0]     abs_target,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             halt,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic             stack_err,
  output logic [CNT_W-1:0] cycle_cnt
);

  pc_state_t        r_state, w_state_next;
  logic [D-1:0]     r_pc, w_pc_next;
  logic             r_err, w_err_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  pc_src_t          w_src;
  logic             w_push, w_pop, w_clr;
  logic [D-1:0]     w_stk_top;
  logic             w_stk_full, w_stk_empty;

  ret_stack #(
    .D     (D),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (w_clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_pc + D'(1)),
    .dout  (w_stk_top),
    .full  (w_stk_full),
    .empty (w_stk_empty)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_err_next   = r_err;
    w_cnt_next   = r_cnt;
    w_src        = SRC_HOLD;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_clr        = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        if (!stall) begin
          w_cnt_next = r_cnt + CNT_W'(1);
          // Strict priority; stack faults halt without moving the PC.
          if (halt) begin
            w_state_next = HALTED;
          end else if (ret_en) begin
            if (w_stk_empty) begin
              w_err_next   = 1'b1;
              w_state_next = HALTED;
            end else begin
              w_src = SRC_RET;
              w_pop = 1'b1;
            end
          end else if (call_en) begin
            if (w_stk_full) begin
              w_err_next   = 1'b1;
              w_state_next = HALTED;
            end else begin
              w_src  = SRC_ABS;
              w_push = 1'b1;
            end
          end else if (abs_jump_en) begin
            w_src = SRC_ABS;
          end else if (branch_en) begin
            w_src = SRC_BR;
          end else begin
            w_src = SRC_INC;
          end
        end
      end
      HALTED: begin
        if (start) begin
          w_state_next = RUN;
          w_pc_next    = RESET_PC;
          w_cnt_next   = '0;
          w_clr        = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    case (w_src)
      SRC_INC: w_pc_next = r_pc + D'(1);
      SRC_BR:  w_pc_next = r_pc + target;
      SRC_ABS: w_pc_next = abs_target;
      SRC_RET: w_pc_next = w_stk_top;
      default: ;
    endcase
  end

  assign prog_ctr  = r_pc;
  assign running   = (r_state == RUN);
  assign done      = (r_state == HALTED);
  assign stack_err = r_err;
  assign cycle_cnt = r_cnt;

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Program-counter stage directly downstream of the branch-target lookup table. It consumes the D-bit two's-complement offset produced by the LUT and holds the instruction-fetch address.
- Each cycle it selects the next PC from five sources: sequential increment, relative branch, absolute jump, call (with a small return-address stack), or return.
- It also runs a start/run/halt controller, so the testbench and top level see a clean done handshake.

Parameters:
- D, 12, PC / target width in bits (matches the lookup-table width).
- STACK_DEPTH, 4, number of entries in the return-address stack.
- RESET_PC, 0, PC value on reset and on every restart.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse: IDLE/HALTED -> RUN.
- stall  input  1  freeze PC and state for this cycle (RUN only).
- branch_en  input  1  relative branch taken.
- target  input  D  signed offset from the lookup table.
- abs_jump_en  input  1  absolute jump.
- abs_target  input  D  absolute jump/call address.
- call_en  input  1  push PC+1, then jump to abs_target.
- ret_en  input  1  pop the stack into PC.
- halt  input  1  decoder saw the halt instruction.
- prog_ctr  output  D  current fetch address.
- running  output  1  state == RUN.
- done  output  1  state == HALTED.
- stack_err  output  1  sticky overflow/underflow flag.
- cycle_cnt  output  16  count of non-stalled RUN cycles.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - prog_ctr = RESET_PC; running = 0; done = 0; stack_err = 0; cycle_cnt = 0.
  - Stack pointer = 0. Stack contents are don't-care.
  - Reset asserted mid-RUN aborts immediately with no further PC update.
- States: IDLE, RUN, HALTED. The state is registered; all outputs are registered or decoded directly from state.
- IDLE:
  - prog_ctr holds RESET_PC; all control inputs are ignored.
  - start -> RUN. prog_ctr is unchanged, so the first fetch is at RESET_PC.
- RUN with stall = 1:
  - PC, state, stack and cycle_cnt all hold; every other input is ignored.
- RUN with stall = 0:
  - cycle_cnt increments, wrapping at 2^16.
  - The next PC is chosen by strict priority:
    1. halt: PC holds, state -> HALTED.
    2. ret_en:
       - Stack empty: set stack_err, state -> HALTED, PC holds.
       - Otherwise: PC = top of stack, stack pointer - 1.
    3. call_en:
       - Stack full: set stack_err, state -> HALTED, PC holds.
       - Otherwise: push (PC + 1) mod 2^D, then PC = abs_target.
    4. abs_jump_en: PC = abs_target.
    5. branch_en: PC = (PC + target) mod 2^D. target is two's-complement D-bit; the carry out is discarded.
    6. Otherwise: PC = (PC + 1) mod 2^D, so 2^D-1 wraps to 0.
  - Lower-priority enables asserted in the same cycle are ignored.
- HALTED:
  - done = 1; PC holds; stack_err holds.
  - start -> RUN with PC = RESET_PC, stack pointer = 0, cycle_cnt = 0. stack_err is cleared by Reset only.
- Latency: one cycle. Inputs sampled on edge N appear on prog_ctr after edge N.
- start while in RUN is ignored.

Decomposition:
- Package pc_pkg holds:
  - the pc_state_t enum {IDLE, RUN, HALTED};
  - localparam CNT_W = 16;
  - the next-PC source-select enum {SRC_HOLD, SRC_INC, SRC_BR, SRC_ABS, SRC_RET}.
- One sub-module: ret_stack, a LIFO of STACK_DEPTH × D bits.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Same Clk/Reset; reset clears the pointer only.
- prog_counter contains the FSM, the next-PC mux and the counter.

Test Plan:
- Reset, then start; hold all enables low for 5 cycles -> prog_ctr = 0, 1, 2, 3, 4, 5; running = 1; cycle_cnt = 5.
- From PC = 4: branch_en with target = 24 -> PC = 28. Then branch_en with target = 12'hFE4 (-28) -> PC = 0. Force PC = 12'hFFF, then increment -> PC = 0 (wrap).
- Same cycle: call_en, abs_jump_en and branch_en with abs_target = 100 and PC = 7 -> PC = 100, stack top = 8. Then ret_en -> PC = 8.
- Five consecutive calls (STACK_DEPTH = 4) -> the 5th sets stack_err = 1 and done = 1, PC holds. Separately, ret_en on an empty stack -> same error response.
- stall = 1 for 3 cycles with branch_en = 1 -> PC and cycle_cnt unchanged. halt together with stall -> no halt. halt after stall drops -> done = 1 next cycle.
- Assert Reset asynchronously mid-cycle during RUN at PC = 50 -> prog_ctr = 0, state IDLE and all flags 0 without waiting for a clock edge. start in HALTED -> PC = 0, running = 1.
